i2s_dac_tx: RTL and testbench
=============================

// Module: i2s_dac_tx
// PURPOSE
//  I2S transmitter: the outbound counterpart of the PCM9211 I2S receive path. It takes
//  processed stereo samples from the audio pipeline over a valid/ready handshake.
//  It serialises them to the PCM1792 DAC on dac_bclk, dac_lrclk and dac_data.
//  The FPGA is I2S master, and all serial clocks are derived from clk.
// PARAMETERS
//  BCLK_HALF    8   clk cycles per bclk half-period (>=2); bclk = clk/(2*BCLK_HALF)
//  SAMPLE_BITS  24  sample width, MSB-first, left-aligned in slot
//  SLOT_BITS    32  bclk periods per channel slot; frame = 2*SLOT_BITS bclks
// PORTS
//  clk          in   1            system clock
//  reset        in   1            async, active-high
//  enable       in   1            0: serial outputs idle low, counters cleared
//  mute         in   1            1: frames carry zero data; hold register still drained
//  in_valid     in   1            sample pair valid
//  in_ready     out  1            hold register empty
//  in_left      in   SAMPLE_BITS  left sample, two's complement
//  in_right     in   SAMPLE_BITS  right sample, two's complement
//  dac_bclk     out  1            bit clock; DAC samples on rising edge
//  dac_lrclk    out  1            0 = left slot, 1 = right slot
//  dac_data     out  1            serial data, changes on bclk falling edge
//  frame_start  out  1            1-clk pulse at each frame load
//  underrun     out  1            1-clk pulse when a frame loads with the hold register empty
// BEHAVIOUR
//  - Reset values: dac_bclk=0, dac_lrclk=0, dac_data=0, in_ready=1, frame_start=0, underrun=0.
//    div_cnt=0, bit_cnt=0, frame=0, hold empty. All outputs are registered.
//  - Divider: div_cnt counts 0..BCLK_HALF-1. At the terminal count, bclk toggles.
//    A 1->0 toggle is a fall strobe (fall_stb).
//  - bit_cnt k: 0..2*SLOT_BITS-1, advances on fall_stb and wraps to 0.
//    On the same fall_stb, dac_lrclk <= (k >= SLOT_BITS).
//  - Data lags lrclk by one bclk (I2S):
//    dac_data <= frame[2*SLOT_BITS-1 - ((k-1) mod 2*SLOT_BITS)].
//    frame = {L, pad0, R, pad0}, pad bits zero.
//  - Frame load: on the fall_stb where k becomes 0.
//    Hold full: frame <= hold (or zeros if mute), hold is cleared, frame_start=1.
//    Hold empty: frame <= 0, frame_start=1, underrun=1.
//    The bit output at k=0 is the old frame LSB pad bit, always 0.
//  - Handshake: accept when in_valid && in_ready; the sample is written to hold next cycle.
//    in_ready = !hold_full.
//  - Accept and load in the same cycle with hold empty: the sample goes to hold.
//    The frame loads zeros and underrun pulses. The sample plays next frame.
//  - Latency: a sample accepted just before a load has its left MSB on dac_data
//    one bclk after the lrclk 1->0 edge.
//  - enable=0: div_cnt, bit_cnt and frame clear, and serial outputs drive 0 next cycle.
//    Hold is retained. On enable 0->1, the first bclk rising edge occurs BCLK_HALF clks later.
//    The first fall_stb gives k=0 and triggers a frame load.
//  - enable dropped mid-frame: the frame is abandoned with no underrun pulse.
//  - reset mid-frame: all state returns to reset values asynchronously.
//  - Period: one frame = 4*SLOT_BITS*BCLK_HALF clks exactly. No drift.
// CONFIGURATION
//  I2S_TX_UNDERRUN_CNT_EN defined:
//    Adds port underrun_cnt out 16, a saturating count of underrun pulses.
//    Cleared by reset only, holds at 16'hFFFF.
//  Undefined: the port and counter are absent. underrun pulse behaviour is unchanged.
// STRUCTURE
//  audipus_pkg: SAMPLE_BITS/SLOT_BITS defaults, FRAME_BITS = 2*SLOT_BITS,
//    and a typedef for the stereo sample pair {left, right}.
//  Sub-module i2s_bclk_gen: divider producing bclk, fall_stb and rise_stb.
//  The top level holds bit_cnt, hold, frame, handshake and flags.
// TESTING (BCLK_HALF=2, SAMPLE_BITS=24, SLOT_BITS=32 -> 256 clks/frame)
//  1 Reset: all outputs at reset values, in_ready=1.
//    enable=1, no input: underrun pulses every 256 clks and dac_data stays 0.
//  2 Push L=24'h800001, R=24'h7FFFFE.
//    Checker samples dac_data on bclk rise: bits 1..24 of slot L are 1,0..0,1, then 8 zeros.
//    Slot R gives 0,1..1,0, then zeros. lrclk period = 64 bclks.
//  3 Backpressure: hold in_valid=1 continuously.
//    Exactly one accept per frame, in_ready low between accepts, and no underrun after the first frame.
//  4 in_valid asserted on the exact load cycle with hold empty:
//    underrun=1, zero frame, and the sample appears in the following frame.
//  5 mute=1 with samples streaming: dac_data always 0, in_ready still cycles and no underrun.
//    Deassert enable mid-frame: outputs low within 1 clk. Re-enable: k=0 load at the first fall_stb.
//  6 With I2S_TX_UNDERRUN_CNT_EN: 70000 starved frames give underrun_cnt=16'hFFFF.
//    Reset gives 0.

Source files
------------

// File: rtl/audipus_pkg.sv
// Shared audio-path constants and the stereo sample pair type.
package audipus_pkg;

    localparam int SAMPLE_BITS_DFLT = 24;
    localparam int SLOT_BITS_DFLT   = 32;
    localparam int FRAME_BITS       = 2 * SLOT_BITS_DFLT;

    typedef struct packed {
        logic [SAMPLE_BITS_DFLT-1:0] left;
        logic [SAMPLE_BITS_DFLT-1:0] right;
    } sample_pair_t;

endpackage

// File: rtl/i2s_bclk_gen.sv
// Bit-clock divider: bclk = clk/(2*BCLK_HALF), with single-clk edge strobes
// that coincide with the clock edge on which bclk toggles.
module i2s_bclk_gen #(
    parameter int BCLK_HALF = 8
) (
    input  logic i_clk,
    input  logic i_reset,
    input  logic i_enable,
    output logic o_bclk,
    output logic o_fall_stb,
    output logic o_rise_stb
);
    localparam int DW = (BCLK_HALF > 2) ? $clog2(BCLK_HALF) : 1;

    logic [DW-1:0] r_div_cnt;
    logic          w_tc;

    assign w_tc       = i_enable && (r_div_cnt == DW'(BCLK_HALF - 1));
    assign o_fall_stb = w_tc && o_bclk;
    assign o_rise_stb = w_tc && !o_bclk;

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_div_cnt <= '0;
            o_bclk    <= 1'b0;
        end else if (!i_enable) begin
            r_div_cnt <= '0;
            o_bclk    <= 1'b0;
        end else if (w_tc) begin
            r_div_cnt <= '0;
            o_bclk    <= !o_bclk;
        end else begin
            r_div_cnt <= r_div_cnt + 1'b1;
        end
    end

endmodule

// File: rtl/i2s_dac_tx.sv
// I2S master transmitter for the PCM1792: one-deep hold register feeding a
// frame register serialised MSB-first. Optional I2S_TX_UNDERRUN_CNT_EN adds a
// saturating underrun counter port.
module i2s_dac_tx
    import audipus_pkg::*;
#(
    parameter int BCLK_HALF   = 8,
    parameter int SAMPLE_BITS = SAMPLE_BITS_DFLT,
    parameter int SLOT_BITS   = SLOT_BITS_DFLT
) (
    input  logic                   i_clk,
    input  logic                   i_reset,
    input  logic                   i_enable,
    input  logic                   i_mute,
    input  logic                   i_in_valid,
    output logic                   o_in_ready,
    input  logic [SAMPLE_BITS-1:0] i_in_left,
    input  logic [SAMPLE_BITS-1:0] i_in_right,
    output logic                   o_dac_bclk,
    output logic                   o_dac_lrclk,
    output logic                   o_dac_data,
    output logic                   o_frame_start,
    output logic                   o_underrun
`ifdef I2S_TX_UNDERRUN_CNT_EN
    ,
    output logic [15:0]            o_underrun_cnt
`endif
);
    localparam int FRAME_W = 2 * SLOT_BITS;
    localparam int KW      = $clog2(FRAME_W);

    logic                   w_fall_stb;
    logic                   w_load;
    logic                   w_accept;
    logic [KW-1:0]          w_k_next;
    logic [KW-1:0]          w_idx;
    logic [FRAME_W-1:0]     w_frame_new;

    logic                   r_started;
    logic [KW-1:0]          r_bit_cnt;
    logic [FRAME_W-1:0]     r_frame;
    logic                   r_hold_full;
    logic [SAMPLE_BITS-1:0] r_hold_l;
    logic [SAMPLE_BITS-1:0] r_hold_r;

    i2s_bclk_gen #(.BCLK_HALF(BCLK_HALF)) u_bclk_gen (
        .i_clk      (i_clk),
        .i_reset    (i_reset),
        .i_enable   (i_enable),
        .o_bclk     (o_dac_bclk),
        .o_fall_stb (w_fall_stb),
        .o_rise_stb ()
    );

    // The first fall strobe after enable is forced to k=0 so it always loads a frame.
    always_comb begin
        w_accept = i_in_valid && o_in_ready;
        if (!r_started || (r_bit_cnt == KW'(FRAME_W - 1)))
            w_k_next = '0;
        else
            w_k_next = r_bit_cnt + 1'b1;
        w_load = w_fall_stb && (w_k_next == '0);
        // Bit k carries frame bit FRAME_W-k; k=0 reads the old frame's pad LSB.
        w_idx = (w_k_next == '0) ? '0 : KW'(FRAME_W) - w_k_next;
        w_frame_new = '0;
        if (r_hold_full && !i_mute)
            w_frame_new = (FRAME_W'(r_hold_l) << (FRAME_W - SAMPLE_BITS))
                        | (FRAME_W'(r_hold_r) << (SLOT_BITS - SAMPLE_BITS));
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_hold_full <= 1'b0;
            o_in_ready  <= 1'b1;
            r_hold_l    <= '0;
            r_hold_r    <= '0;
        end else if (w_accept) begin
            r_hold_l    <= i_in_left;
            r_hold_r    <= i_in_right;
            r_hold_full <= 1'b1;
            o_in_ready  <= 1'b0;
        end else if (w_load && r_hold_full) begin
            r_hold_full <= 1'b0;
            o_in_ready  <= 1'b1;
        end
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_started     <= 1'b0;
            r_bit_cnt     <= '0;
            r_frame       <= '0;
            o_dac_lrclk   <= 1'b0;
            o_dac_data    <= 1'b0;
            o_frame_start <= 1'b0;
            o_underrun    <= 1'b0;
        end else begin
            o_frame_start <= 1'b0;
            o_underrun    <= 1'b0;
            if (!i_enable) begin
                r_started   <= 1'b0;
                r_bit_cnt   <= '0;
                r_frame     <= '0;
                o_dac_lrclk <= 1'b0;
                o_dac_data  <= 1'b0;
            end else if (w_fall_stb) begin
                r_started   <= 1'b1;
                r_bit_cnt   <= w_k_next;
                o_dac_lrclk <= (w_k_next >= KW'(SLOT_BITS));
                o_dac_data  <= r_frame[w_idx];
                if (w_load) begin
                    r_frame       <= w_frame_new;
                    o_frame_start <= 1'b1;
                    o_underrun    <= !r_hold_full;
                end
            end
        end
    end

`ifdef I2S_TX_UNDERRUN_CNT_EN
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset)
            o_underrun_cnt <= '0;
        else if (w_load && !r_hold_full && (o_underrun_cnt != 16'hFFFF))
            o_underrun_cnt <= o_underrun_cnt + 16'd1;
    end
`endif

endmodule

// File: tb/tb_i2s_dac_tx.sv
// Directed bench for i2s_dac_tx at BCLK_HALF=2 (256 clks per frame).
module tb_i2s_dac_tx;
    import audipus_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        enable = 1'b0;
    logic        mute = 1'b0;
    logic        in_valid = 1'b0;
    logic [23:0] in_left = '0;
    logic [23:0] in_right = '0;
    logic        in_ready, dac_bclk, dac_lrclk, dac_data, frame_start, underrun;
`ifdef I2S_TX_UNDERRUN_CNT_EN
    logic [15:0] underrun_cnt;
    int          urun_seen;
`endif

    int pass_cnt = 0;
    int total_cnt = 0;
    localparam logic [63:0] EXP_LR = {32'hFFFF_FFFF, 32'h0000_0000};

    always #5 clk = ~clk;

    i2s_dac_tx #(.BCLK_HALF(2), .SAMPLE_BITS(24), .SLOT_BITS(32)) dut (
        .i_clk         (clk),
        .i_reset       (rst),
        .i_enable      (enable),
        .i_mute        (mute),
        .i_in_valid    (in_valid),
        .o_in_ready    (in_ready),
        .i_in_left     (in_left),
        .i_in_right    (in_right),
        .o_dac_bclk    (dac_bclk),
        .o_dac_lrclk   (dac_lrclk),
        .o_dac_data    (dac_data),
        .o_frame_start (frame_start),
        .o_underrun    (underrun)
`ifdef I2S_TX_UNDERRUN_CNT_EN
        ,
        .o_underrun_cnt(underrun_cnt)
`endif
    );

`ifdef I2S_TX_UNDERRUN_CNT_EN
    always @(negedge clk or posedge rst)
        if (rst) urun_seen <= 0;
        else if (underrun) urun_seen <= urun_seen + 1;
`endif

    // Bit k of the capture is expected to carry frame bit 64-k; k=0 is the old pad LSB.
    function automatic logic [63:0] exp_bits(input logic [23:0] l, input logic [23:0] r);
        logic [63:0] f;
        logic [63:0] e;
        f = {l, 8'h00, r, 8'h00};
        e = '0;
        for (int k = 1; k < 64; k++) e[k] = f[64-k];
        return e;
    endfunction

    task automatic wait_fs(output bit ok, output int n);
        ok = 0;
        n = 0;
        for (int i = 1; i <= 600; i++) begin
            @(negedge clk);
            if (frame_start) begin
                ok = 1;
                n = i;
                break;
            end
        end
    endtask

    task automatic capture(output logic [63:0] bits, output logic [63:0] lr, output bit ok);
        logic prev;
        int   k;
        k = 0;
        bits = '0;
        lr = '0;
        prev = dac_bclk;
        for (int i = 0; i < 300 && k < 64; i++) begin
            @(negedge clk);
            if (dac_bclk && !prev) begin
                bits[k] = dac_data;
                lr[k] = dac_lrclk;
                k++;
            end
            prev = dac_bclk;
        end
        ok = (k == 64);
    endtask

    task automatic test_reset;
        bit ok;
        int n;
        logic [63:0] bits, lr;
        rst = 1'b1;
        repeat (2) @(negedge clk);
        total_cnt++;
        if ({dac_bclk, dac_lrclk, dac_data, frame_start, underrun} !== 5'b0) $display("FAIL reset_outputs: got %b expected 00000", {dac_bclk, dac_lrclk, dac_data, frame_start, underrun});
        else pass_cnt++;
        total_cnt++;
        if (in_ready !== 1'b1) $display("FAIL reset_ready: got %b expected 1", in_ready);
        else pass_cnt++;
`ifdef I2S_TX_UNDERRUN_CNT_EN
        total_cnt++;
        if (underrun_cnt !== 16'h0) $display("FAIL reset_urun_cnt: got %0h expected 0", underrun_cnt);
        else pass_cnt++;
`endif
        rst = 1'b0;
        @(negedge clk);
        enable = 1'b1;
        wait_fs(ok, n);
        total_cnt++;
        if (!ok || underrun !== 1'b1) $display("FAIL starve_first_underrun: got ok=%0d ur=%b expected ok=1 ur=1", ok, underrun);
        else pass_cnt++;
        wait_fs(ok, n);
        total_cnt++;
        if (!ok || n != 256) $display("FAIL frame_period: got %0d clks expected 256", n);
        else pass_cnt++;
        total_cnt++;
        if (underrun !== 1'b1) $display("FAIL starve_underrun: got %b expected 1", underrun);
        else pass_cnt++;
        capture(bits, lr, ok);
        total_cnt++;
        if (!ok || bits !== 64'h0) $display("FAIL starve_data: got %h expected 0", bits);
        else pass_cnt++;
        total_cnt++;
        if (lr !== EXP_LR) $display("FAIL starve_lrclk: got %h expected %h", lr, EXP_LR);
        else pass_cnt++;
    endtask

    task automatic test_stream;
        bit ok;
        int n;
        sample_pair_t s;
        logic [63:0] bits, lr;
        s.left = 24'h800001;
        s.right = 24'h7FFFFE;
        wait_fs(ok, n);
        in_left = s.left;
        in_right = s.right;
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        total_cnt++;
        if (in_ready !== 1'b0) $display("FAIL stream_ready_low: got %b expected 0", in_ready);
        else pass_cnt++;
        wait_fs(ok, n);
        total_cnt++;
        if (!ok || underrun !== 1'b0 || in_ready !== 1'b1) $display("FAIL stream_load: got ok=%0d ur=%b rdy=%b expected 1 0 1", ok, underrun, in_ready);
        else pass_cnt++;
        capture(bits, lr, ok);
        total_cnt++;
        if (!ok || bits[1] !== 1'b1 || bits[24] !== 1'b1 || bits[2] !== 1'b0 || bits[33] !== 1'b0 || bits[34] !== 1'b1 || bits[56] !== 1'b0)
            $display("FAIL stream_key_bits: got %h", bits);
        else pass_cnt++;
        total_cnt++;
        if (bits !== exp_bits(s.left, s.right)) $display("FAIL stream_frame: got %h expected %h", bits, exp_bits(s.left, s.right));
        else pass_cnt++;
        total_cnt++;
        if (lr !== EXP_LR) $display("FAIL stream_lrclk: got %h expected %h", lr, EXP_LR);
        else pass_cnt++;
    endtask

    task automatic test_backpressure;
        bit ok;
        int n, acc, ur, rdy_low;
        acc = 0; ur = 0; rdy_low = 0;
        wait_fs(ok, n);
        in_left = 24'h0F0F0F;
        in_right = 24'hF0F0F0;
        in_valid = 1'b1;
        for (int i = 0; i < 768; i++) begin
            if (i > 0) @(negedge clk);
            if (in_ready) acc++;
            else rdy_low++;
            if (i > 0 && underrun) ur++;
        end
        @(negedge clk);
        in_valid = 1'b0;
        total_cnt++;
        if (acc != 3) $display("FAIL bp_accepts: got %0d expected 3", acc);
        else pass_cnt++;
        total_cnt++;
        if (rdy_low != 765) $display("FAIL bp_ready_low: got %0d expected 765", rdy_low);
        else pass_cnt++;
        total_cnt++;
        if (ur != 0 || underrun !== 1'b0) $display("FAIL bp_underrun: got %0d expected 0", ur);
        else pass_cnt++;
    endtask

    task automatic test_load_collision;
        bit ok;
        int n;
        logic [63:0] bits, lr;
        wait_fs(ok, n);
        repeat (255) @(negedge clk);
        in_left = 24'h123456;
        in_right = 24'hABCDEF;
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        total_cnt++;
        if ({frame_start, underrun, in_ready} !== 3'b110) $display("FAIL collide_load: got fs/ur/rdy=%b expected 110", {frame_start, underrun, in_ready});
        else pass_cnt++;
        capture(bits, lr, ok);
        total_cnt++;
        if (!ok || bits !== 64'h0) $display("FAIL collide_zero_frame: got %h expected 0", bits);
        else pass_cnt++;
        wait_fs(ok, n);
        total_cnt++;
        if (!ok || underrun !== 1'b0) $display("FAIL collide_next_load: got ur=%b expected 0", underrun);
        else pass_cnt++;
        capture(bits, lr, ok);
        total_cnt++;
        if (!ok || bits !== exp_bits(24'h123456, 24'hABCDEF)) $display("FAIL collide_next_frame: got %h expected %h", bits, exp_bits(24'h123456, 24'hABCDEF));
        else pass_cnt++;
    endtask

    task automatic test_mute_enable;
        bit ok;
        int n, acc, ur, ones, idle_bad;
        logic [3:0] bseq, fseq, useq;
        acc = 0; ur = 0; ones = 0; idle_bad = 0;
        wait_fs(ok, n);
        mute = 1'b1;
        in_left = 24'hFFFFFF;
        in_right = 24'hFFFFFF;
        in_valid = 1'b1;
        for (int i = 0; i <= 512; i++) begin
            if (i > 0) @(negedge clk);
            if (i == 512) in_valid = 1'b0;
            if (i < 512 && in_ready) acc++;
            if (i > 0 && underrun) ur++;
            if (dac_data) ones++;
        end
        mute = 1'b0;
        total_cnt++;
        if (ones != 0) $display("FAIL mute_data: got %0d ones expected 0", ones);
        else pass_cnt++;
        total_cnt++;
        if (acc != 2 || ur != 0) $display("FAIL mute_handshake: got acc=%0d ur=%0d expected 2 0", acc, ur);
        else pass_cnt++;
        repeat (150) @(negedge clk);
        total_cnt++;
        if (dac_lrclk !== 1'b1) $display("FAIL pre_disable_lrclk: got %b expected 1", dac_lrclk);
        else pass_cnt++;
        enable = 1'b0;
        @(negedge clk);
        total_cnt++;
        if ({dac_bclk, dac_lrclk, dac_data} !== 3'b000) $display("FAIL disable_outputs: got %b expected 000", {dac_bclk, dac_lrclk, dac_data});
        else pass_cnt++;
        repeat (20) begin
            @(negedge clk);
            if (dac_bclk || dac_lrclk || frame_start || underrun) idle_bad++;
        end
        total_cnt++;
        if (idle_bad != 0) $display("FAIL disable_idle: got %0d active cycles expected 0", idle_bad);
        else pass_cnt++;
        enable = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            bseq[i] = dac_bclk;
            fseq[i] = frame_start;
            useq[i] = underrun;
        end
        total_cnt++;
        if (bseq !== 4'b0110) $display("FAIL reenable_bclk: got %b expected 0110", bseq);
        else pass_cnt++;
        total_cnt++;
        if (fseq !== 4'b1000 || useq !== 4'b1000) $display("FAIL reenable_load: got fs=%b ur=%b expected 1000 1000", fseq, useq);
        else pass_cnt++;
    endtask

    task automatic test_reset_mid;
        bit ok;
        int n;
`ifdef I2S_TX_UNDERRUN_CNT_EN
        @(negedge clk);
        #1;
        total_cnt++;
        if (int'(underrun_cnt) != urun_seen) $display("FAIL urun_cnt: got %0d expected %0d", underrun_cnt, urun_seen);
        else pass_cnt++;
`endif
        wait_fs(ok, n);
        repeat (150) @(negedge clk);
        total_cnt++;
        if (dac_lrclk !== 1'b1) $display("FAIL pre_reset_lrclk: got %b expected 1", dac_lrclk);
        else pass_cnt++;
        rst = 1'b1;
        #1;
        total_cnt++;
        if ({dac_bclk, dac_lrclk, dac_data, frame_start, underrun, in_ready} !== 6'b000001)
            $display("FAIL reset_mid: got %b expected 000001", {dac_bclk, dac_lrclk, dac_data, frame_start, underrun, in_ready});
        else pass_cnt++;
`ifdef I2S_TX_UNDERRUN_CNT_EN
        total_cnt++;
        if (underrun_cnt !== 16'h0) $display("FAIL reset_mid_urun_cnt: got %0h expected 0", underrun_cnt);
        else pass_cnt++;
`endif
        @(negedge clk);
        rst = 1'b0;
        enable = 1'b0;
    endtask

    initial begin
        test_reset;
        test_stream;
        test_backpressure;
        test_load_collision;
        test_mute_enable;
        test_reset_mid;
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
